// File: rtl/gemm_result_drain_if.sv
// Streaming side of the GEMM result drain: one C element per valid/ready handshake,
// tagged with its row/column position and saturation flag.
interface gemm_result_drain_if #(
  parameter int M         = 4,
  parameter int N         = 4,
  parameter int OUT_WIDTH = 32
) ();
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic [RW-1:0]        out_row;
  logic [CW-1:0]        out_col;
  logic                 out_last;
  logic                 out_sat;

  modport master (
    output out_valid, out_data, out_row, out_col, out_last, out_sat,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_col, out_last, out_sat,
    output out_ready
  );
endinterface

// File: rtl/gemm_result_drain.sv
// Snapshots the systolic array's M x N accumulator matrix on a capture pulse and
// streams it out row-major, one element per handshake, with optional signed saturation.
module gemm_result_drain #(
  parameter int M         = 4,
  parameter int N         = 4,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [M*N*ACC_WIDTH-1:0] c_flat,
  input  logic                     capture,
  output logic                     busy,
  output logic                     overrun,
  gemm_result_drain_if.master      dout
);
  localparam int E  = M * N;
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (E > 1) ? $clog2(E) : 1;

  localparam logic [RW-1:0] ROW_LAST   = RW'(M - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(N - 1);
  localparam logic          FIRST_LAST = (E == 1);

  // Output range expressed at accumulator width; at equal widths these are the
  // accumulator's own extremes, so clipping can never trigger.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, STREAM} state_t;

  // Returns {clipped, value}.
  function automatic logic [OUT_WIDTH:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
    if (v > SAT_MAX)      return {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
    else if (v < SAT_MIN) return {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
    else                  return {1'b0, v[OUT_WIDTH-1:0]};
  endfunction

  logic signed [ACC_WIDTH-1:0] r_buf [E];
  state_t                      r_state;
  logic [IW-1:0]               r_idx;
  logic                        r_overrun;

  logic              w_hs, w_final, w_cap_ok, w_next_last;
  logic [IW-1:0]     w_next_idx;
  logic [RW-1:0]     w_next_row;
  logic [CW-1:0]     w_next_col;
  logic [OUT_WIDTH:0] w_first_sat, w_next_sat;

  assign w_hs     = dout.out_valid && dout.out_ready;
  assign w_final  = w_hs && dout.out_last;
  assign w_cap_ok = capture && ((r_state == IDLE) || w_final);

  assign w_next_idx  = r_idx + 1'b1;
  assign w_next_row  = (dout.out_col == COL_LAST) ? dout.out_row + 1'b1 : dout.out_row;
  assign w_next_col  = (dout.out_col == COL_LAST) ? '0 : dout.out_col + 1'b1;
  assign w_next_last = (w_next_row == ROW_LAST) && (w_next_col == COL_LAST);

  // Element (0,0) comes straight from the input so it is visible the cycle after capture.
  assign w_first_sat = saturate(c_flat[ACC_WIDTH-1:0]);
  assign w_next_sat  = saturate(r_buf[w_next_idx]);

  // NOTE: the frame buffer has no reset; the FSM never presents it outside STREAM,
  // and STREAM is only entered through a capture that overwrites every entry.
  always_ff @(posedge clk) begin
    if (w_cap_ok) begin
      for (int k = 0; k < E; k++) begin
        r_buf[k] <= c_flat[k*ACC_WIDTH +: ACC_WIDTH];
      end
    end
  end

  // NOTE: non-blocking assignments throughout, so every decision below sees the
  // pre-edge values of the state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_idx          <= '0;
      r_overrun      <= 1'b0;
      dout.out_valid <= 1'b0;
      dout.out_data  <= '0;
      dout.out_row   <= '0;
      dout.out_col   <= '0;
      dout.out_last  <= 1'b0;
      dout.out_sat   <= 1'b0;
    end else begin
      r_overrun <= capture && (r_state == STREAM) && !w_final;
      if (w_cap_ok) begin
        r_state        <= STREAM;
        r_idx          <= '0;
        dout.out_valid <= 1'b1;
        dout.out_data  <= w_first_sat[OUT_WIDTH-1:0];
        dout.out_sat   <= w_first_sat[OUT_WIDTH];
        dout.out_row   <= '0;
        dout.out_col   <= '0;
        dout.out_last  <= FIRST_LAST;
      end else if (w_final) begin
        r_state        <= IDLE;
        dout.out_valid <= 1'b0;
        dout.out_last  <= 1'b0;
      end else if (w_hs) begin
        r_idx          <= w_next_idx;
        dout.out_data  <= w_next_sat[OUT_WIDTH-1:0];
        dout.out_sat   <= w_next_sat[OUT_WIDTH];
        dout.out_row   <= w_next_row;
        dout.out_col   <= w_next_col;
        dout.out_last  <= w_next_last;
      end
    end
  end

  assign busy    = (r_state == STREAM);
  assign overrun = r_overrun;
endmodule

// File: doc/gemm_result_drain.md
# gemm_result_drain

Result-side unloader for the GEMM systolic array. On a capture pulse it snapshots the array's full M×N accumulator matrix C into a local buffer. It then streams the elements out one per handshake, in row-major order, over a valid/ready interface, with optional signed saturation to a narrower output width. It sits between the SystolicArray C outputs and the downstream memory writer or host FIFO, freeing the array to start the next tile while the previous result drains.

## Interface

- M, 4, rows of C
- N, 4, columns of C
- ACC_WIDTH, 32, width of each C accumulator element (signed)
- OUT_WIDTH, 32, width of each streamed element (signed); 2 ≤ OUT_WIDTH ≤ ACC_WIDTH
- clk  input  1  rising-edge clock; sole clock domain
- reset  input  1  synchronous, active-high reset
- c_flat  input  M*N*ACC_WIDTH  packed C; element (i,j) occupies bits [(i*N+j)*ACC_WIDTH +: ACC_WIDTH]
- capture  input  1  single-cycle request to snapshot c_flat
- busy  output  1  high while a frame is buffered and not fully drained
- overrun  output  1  one-cycle pulse when a capture is rejected
- out_valid  output  1  out_data holds a valid element
- out_ready  input  1  downstream accepts the element when high together with out_valid
- out_data  output  OUT_WIDTH  current element, saturated
- out_row  output  clog2(M) (min 1)  row index i of out_data
- out_col  output  clog2(N) (min 1)  column index j of out_data
- out_last  output  1  high with element (M-1,N-1)
- out_sat  output  1  current element was clipped by saturation

## Operation

- States: IDLE, STREAM.
- IDLE: out_valid=0. When capture=1, latch all M*N elements of c_flat into the buffer, set the index to (0,0), and enter STREAM.
- STREAM: out_valid=1 and the outputs present element (row,col). A handshake occurs when out_valid && out_ready. On a handshake, col increments; on col wrap N-1→0, row increments.
- Handshake on element (M-1,N-1) with no accepted capture: enter IDLE.
- Capture acceptance: capture is accepted in IDLE, or in STREAM on the same cycle as the final handshake. In the second case, the new frame is latched and streaming continues back-to-back at (0,0) with no bubble.
- Capture rejection: capture in STREAM without a final handshake is ignored. The buffer is unchanged and overrun pulses high for the next cycle.
- Saturation: when OUT_WIDTH < ACC_WIDTH, a value above 2^(OUT_WIDTH-1)-1 outputs MAX, and a value below -2^(OUT_WIDTH-1) outputs MIN. Either case sets out_sat=1. Otherwise out_data is the truncated value and out_sat=0. When OUT_WIDTH = ACC_WIDTH, values pass through and out_sat=0 always.
- Stall: out_data, out_row, out_col, out_last and out_sat hold stable while out_valid && !out_ready.
- busy equals (state == STREAM).

## Timing

- All outputs are registered.
- Reset values: out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, out_sat=0, busy=0, overrun=0, state IDLE.
- Reset mid-stream aborts the frame: no further elements are emitted and the buffered data is discarded.
- Capture latency: capture sampled high at edge t gives out_valid=1 with element (0,0) after edge t. That is, the first element is visible in the cycle after the capture cycle.
- c_flat is sampled only at the capture edge and may change freely afterwards.
- Throughput: one element per cycle with out_ready held high, so a frame takes M*N cycles.
- Frame boundary: after the final handshake (no capture), out_valid=0 and busy=0 in the next cycle.
- overrun is asserted exactly one cycle after the rejected capture, and for one cycle only.
- out_valid never drops without a handshake while in STREAM.

## Test plan

- Basic drain: default parameters, c_flat = row-major {8,-11,-30,31, -12,29,16,71, 33,-14,-61,98, 2,37,18,-103}, capture pulse, out_ready=1.
  - Required: 16 consecutive valid cycles in exactly that order, with correct out_row/out_col.
  - Required: out_last only on -103, then out_valid=0 and busy=0.
- Backpressure: same frame, out_ready toggling 1,0,0,1,… (pseudo-random).
  - Required: the output sequence is identical to the basic drain.
  - Required: outputs are stable during every stall cycle, and no element is dropped or duplicated.
- Saturation: OUT_WIDTH=8, element values 200, -300, 127, -128, -103 placed in the frame.
  - Required: outputs 127 (out_sat=1), -128 (out_sat=1), 127 (0), -128 (0), -103 (0).
- Overrun and back-to-back:
  - Capture at element 5 of a frame → overrun pulse, and the frame completes unchanged.
  - Capture on the final handshake cycle → next cycle shows the new frame's element (0,0) with out_valid=1 and no bubble.
- Snapshot isolation: change c_flat every cycle after capture.
  - Required: the streamed data equals the values present at the capture edge.
- Reset mid-operation: assert reset during element 7 with out_ready=1.
  - Required: in the next cycle every output is at its reset value and busy=0.
  - Required: a subsequent capture streams a fresh frame from (0,0).
